seq_mult_shift_add: RTL and testbench
=====================================

Name: seq_mult_shift_add

Overview:
Parametrised sequential shift-and-accumulate multiplier. It generalises the fixed 32-bit shift-right accumulator datapath to any operand width and adds a signed two's-complement mode, a start/busy/done handshake, abort, and a held, registered product. It sits behind the control FSM as a single multi-cycle arithmetic unit and retires one multiplier bit per cycle.

Parameters:
WIDTH, 32, operand width in bits (≥2); product is 2*WIDTH.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
signed_mode  input  1  sampled at accept; 1 = two's-complement operands
multiplicand  input  WIDTH  M operand, sampled at accept
multiplier  input  WIDTH  Q operand, sampled at accept
abort  input  1  synchronous cancel of a running operation
busy  output  1  high while the operation is in progress
done  output  1  one-cycle pulse when the product register is updated
product_valid  output  1  level; product holds a completed result
product  output  2*WIDTH  registered result

Behaviour:
- Reset (reset_n=0, async): state=IDLE; busy=0, done=0, product_valid=0, product=0; internal A, Q, M, counter all cleared.
- States: IDLE, RUN.
- IDLE with start=1 (accept edge): load M<=multiplicand, Q<=multiplier, A<=0 (WIDTH+1 bits), cnt<=0, latch signed_mode; busy<=1; product_valid<=0; product keeps its old value; go to RUN.
- RUN, each edge (one iteration):
  - sum = A + ext(M) if Q[0]=1, else A.
  - ext = zero-extension in unsigned mode, sign-extension in signed mode.
  - Signed mode on the last iteration (cnt=WIDTH-1): sum = A - ext(M) if Q[0]=1.
  - Shift {sum,Q} right by 1.
  - MSB fill: unsigned uses the carry bit sum[WIDTH]; signed is arithmetic (sum[WIDTH] replicated, with A held as WIDTH+1 bits so overflow is not lost).
  - cnt<=cnt+1.
- Iteration with cnt=WIDTH-1 is the last:
  - product<={A[WIDTH-1:0],Q} after that shift.
  - done=1 for exactly that following cycle; product_valid<=1; busy<=0; go to IDLE.
- Latency: accept at edge k; product/done/product_valid visible after edge k+WIDTH. Next start may be accepted in the cycle done is high, giving back-to-back throughput of one result per WIDTH+1 cycles.
- start while busy=1: ignored, with no effect on operands or mode.
- Operand inputs may change freely after accept.
- abort=1 in RUN: next edge returns to IDLE; busy=0; no done; product_valid stays 0; product unchanged.
  - abort in IDLE: ignored.
  - abort and start together in IDLE: start wins.
- Reset mid-operation: immediate clear as above; no done.
- Unsigned range: full 2*WIDTH result, never overflows.
- Signed range: exact for all inputs, including (-2^(WIDTH-1))*(-2^(WIDTH-1)) = 2^(2*WIDTH-2).

Decomposition:
- Package seq_mult_pkg: state enum {IDLE, RUN}; helper function for counter width.
- Sub-module seq_mult_datapath holds A/Q/M registers, the adder/subtractor and the shift mux.
  - Controls: load, step, last, signed.
  - Outputs: A, Q, lsb.
- Top holds the FSM, counter and output registers.

Test Plan:
1. WIDTH=8, unsigned, 5×7 → product=0x0023 after exactly 8 cycles; done high 1 cycle; busy low next cycle.
2. WIDTH=8, unsigned, 255×255 → product=0xFE01, with no carry loss.
3. WIDTH=8, signed, -3×5 (0xFD, 0x05) → 0xFFF1; signed -128×-128 (0x80, 0x80) → 0x4000; signed 127×-1 → 0xFF81.
4. Start pulse plus changed operands mid-RUN → ignored; original product is delivered at the original cycle. Back-to-back start in the done cycle → accepted; second result 8 cycles later.
5. Abort at iteration 4 → busy=0 next cycle, no done, product_valid=0, product still shows the previous result.
6. reset_n low mid-RUN (asynchronous, between edges) → all outputs 0 immediately. WIDTH=32 regression: 0xFFFFFFFF×0xFFFFFFFF unsigned → 0xFFFFFFFE00000001.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package seq_mult_pkg;

    // Control FSM states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Iteration counter width: enough bits to count from 0 up to w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : seq_mult_pkg

// File: rtl/seq_mult_datapath.sv
// A/Q/M registers, adder/subtractor and shift mux of the shift-and-add multiplier.
// A is kept one bit wider than the operands so that the signed sum never loses
// its sign and the unsigned sum never loses its carry.
module seq_mult_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             last_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic [WIDTH:0]   a_nxt_o,
    output logic [WIDTH-1:0] q_nxt_o,
    output logic             lsb_o
);

    logic [WIDTH:0]   a_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] m_q;

    logic [WIDTH:0]   m_ext_s;
    logic [WIDTH:0]   sum_s;
    logic             fill_s;

    // One iteration: conditional add (or subtract for the signed sign bit), then shift right.
    always_comb begin
        m_ext_s = {1'b0, m_q};
        sum_s   = a_q;
        fill_s  = 1'b0;
        if (signed_i) begin
            m_ext_s = {m_q[WIDTH-1], m_q};
            fill_s  = 1'b0;
        end else begin
            m_ext_s = {1'b0, m_q};
            fill_s  = 1'b0;
        end
        if (q_q[0]) begin
            if (signed_i && last_i) begin
                // The multiplier's MSB carries negative weight in two's complement.
                sum_s = a_q - m_ext_s;
            end else begin
                sum_s = a_q + m_ext_s;
            end
        end else begin
            sum_s = a_q;
        end
        // Signed shifts are arithmetic; unsigned shifts bring the carry down into A[WIDTH-1].
        if (signed_i) begin
            fill_s = sum_s[WIDTH];
        end else begin
            fill_s = 1'b0;
        end
        a_nxt_o = {fill_s, sum_s[WIDTH:1]};
        q_nxt_o = {sum_s[0], q_q[WIDTH-1:1]};
    end

    assign lsb_o = q_q[0];

    // Operand registers: load on accept, advance on each iteration, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= {(WIDTH+1){1'b0}};
            q_q <= {WIDTH{1'b0}};
            m_q <= {WIDTH{1'b0}};
        end else if (load_i) begin
            a_q <= {(WIDTH+1){1'b0}};
            q_q <= mplier_i;
            m_q <= mcand_i;
        end else if (step_i) begin
            a_q <= a_nxt_o;
            q_q <= q_nxt_o;
        end else begin
            a_q <= a_q;
            q_q <= q_q;
        end
    end

endmodule : seq_mult_datapath

// File: rtl/seq_mult_shift_add.sv
// Sequential shift-and-add multiplier: control FSM, iteration counter and
// held result registers around the A/Q/M datapath. One multiplier bit per cycle.
module seq_mult_shift_add
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               product_valid,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               signed_q;
    logic               busy_q;
    logic               done_q;
    logic               pvalid_q;
    logic [2*WIDTH-1:0] product_q;

    logic               load_s;
    logic               step_s;
    logic               finish_s;
    logic               last_s;
    logic [WIDTH:0]     dp_a_nxt_s;
    logic [WIDTH-1:0]   dp_q_nxt_s;
    logic               dp_lsb_s;
    logic               unused_s;

    assign last_s   = (cnt_q == CNT_W'(WIDTH - 1));
    // Only the low WIDTH bits of A form the product; A's guard bit and Q[0] are internal.
    assign unused_s = ^{dp_a_nxt_s[WIDTH], dp_lsb_s};

    seq_mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (load_s),
        .step_i   (step_s),
        .last_i   (last_s),
        .signed_i (signed_q),
        .mcand_i  (multiplicand),
        .mplier_i (multiplier),
        .a_nxt_o  (dp_a_nxt_s),
        .q_nxt_o  (dp_q_nxt_s),
        .lsb_o    (dp_lsb_s)
    );

    // Next-state logic: accept in IDLE (start beats abort), iterate or cancel in RUN.
    always_comb begin
        state_d  = state_q;
        load_s   = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_s  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_s) begin
                    step_s   = 1'b1;
                    finish_s = 1'b1;
                    state_d  = IDLE;
                end else begin
                    step_s  = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, latched mode and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= {CNT_W{1'b0}};
            signed_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pvalid_q  <= 1'b0;
            product_q <= {(2*WIDTH){1'b0}};
        end else begin
            busy_q <= (state_d == RUN);
            done_q <= finish_s;
            if (load_s) begin
                cnt_q    <= {CNT_W{1'b0}};
                signed_q <= signed_mode;
                pvalid_q <= 1'b0;
            end else if (step_s) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= cnt_q;
            end
            if (finish_s) begin
                pvalid_q  <= 1'b1;
                product_q <= {dp_a_nxt_s[WIDTH-1:0], dp_q_nxt_s};
            end else begin
                product_q <= product_q;
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign product_valid = pvalid_q;
    assign product       = product_q;

endmodule : seq_mult_shift_add

// File: tb/tb_seq_mult_shift_add.sv
// Directed bench for seq_mult_shift_add: an 8-bit instance for the functional
// cases and a 32-bit instance for the wide regressions.
module tb_seq_mult_shift_add;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        start8 = 1'b0, sm8 = 1'b0, ab8 = 1'b0;
    logic [7:0]  mc8 = 8'h00, mp8 = 8'h00;
    logic        busy8, done8, pv8;
    logic [15:0] prod8;

    logic        start32 = 1'b0, sm32 = 1'b0, ab32 = 1'b0;
    logic [31:0] mc32 = 32'h0, mp32 = 32'h0;
    logic        busy32, done32, pv32;
    logic [63:0] prod32;

    int checks = 0;
    int errors = 0;
    int cyc;
    int done_seen;

    seq_mult_shift_add #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .signed_mode(sm8),
        .multiplicand(mc8), .multiplier(mp8), .abort(ab8),
        .busy(busy8), .done(done8), .product_valid(pv8), .product(prod8)
    );

    seq_mult_shift_add #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .start(start32), .signed_mode(sm32),
        .multiplicand(mc32), .multiplier(mp32), .abort(ab32),
        .busy(busy32), .done(done32), .product_valid(pv32), .product(prod32)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done on the 8-bit instance, counting cycles since accept.
    task automatic wait_done8(input int limit);
        while (!done8 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Full 8-bit operation; returns at the negedge where done is high.
    task automatic run8(input string tag, input logic sm, input logic [7:0] m,
                        input logic [7:0] q, input logic [15:0] exp);
        @(negedge clk);
        start8 = 1'b1; sm8 = sm; mc8 = m; mp8 = q;
        @(negedge clk);
        start8 = 1'b0; mc8 = 8'hA5; mp8 = 8'h5A; sm8 = ~sm;
        check_val({tag, " busy"}, {63'd0, busy8}, 64'd1);
        cyc = 0;
        wait_done8(20);
        check_val({tag, " latency"}, 64'(cyc), 64'd8);
        check_val({tag, " product"}, {48'd0, prod8}, {48'd0, exp});
        check_val({tag, " valid"}, {63'd0, pv8}, 64'd1);
    endtask

    // Full 32-bit operation.
    task automatic run32(input string tag, input logic sm, input logic [31:0] m,
                         input logic [31:0] q, input logic [63:0] exp);
        @(negedge clk);
        start32 = 1'b1; sm32 = sm; mc32 = m; mp32 = q;
        @(negedge clk);
        start32 = 1'b0; mc32 = 32'h0; mp32 = 32'h0;
        cyc = 0;
        while (!done32 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_val({tag, " latency"}, 64'(cyc), 64'd32);
        check_val({tag, " product"}, prod32, exp);
    endtask

    initial begin
        // Reset state.
        #12;
        check_val("rst busy8", {63'd0, busy8}, 64'd0);
        check_val("rst done8", {63'd0, done8}, 64'd0);
        check_val("rst pv8", {63'd0, pv8}, 64'd0);
        check_val("rst prod8", {48'd0, prod8}, 64'd0);
        check_val("rst prod32", prod32, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic unsigned, done pulse width and busy drop.
        run8("u5x7", 1'b0, 8'd5, 8'd7, 16'h0023);
        check_val("u5x7 busy at done", {63'd0, busy8}, 64'd0);
        @(negedge clk);
        check_val("u5x7 done pulse", {63'd0, done8}, 64'd0);
        check_val("u5x7 product held", {48'd0, prod8}, 64'h0023);

        run8("u255x255", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        run8("uFDx05", 1'b0, 8'hFD, 8'h05, 16'h04F1);
        run8("u80x80", 1'b0, 8'h80, 8'h80, 16'h4000);
        run8("u0x9C", 1'b0, 8'h00, 8'h9C, 16'h0000);
        run8("s-3x5", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
        run8("s-128x-128", 1'b1, 8'h80, 8'h80, 16'h4000);
        run8("s127x-1", 1'b1, 8'h7F, 8'hFF, 16'hFF81);
        run8("s-1x-1", 1'b1, 8'hFF, 8'hFF, 16'h0001);
        run8("s127x127", 1'b1, 8'h7F, 8'h7F, 16'h3F01);
        run8("s5x-3", 1'b1, 8'h05, 8'hFD, 16'hFFF1);

        // Start with changed operands while busy is ignored.
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; mc8 = 8'd5; mp8 = 8'd7;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        repeat (3) begin
            @(negedge clk);
            cyc++;
        end
        start8 = 1'b1; sm8 = 1'b1; mc8 = 8'hFF; mp8 = 8'hFF;
        @(negedge clk);
        cyc++;
        start8 = 1'b0;
        wait_done8(20);
        check_val("busy-start latency", 64'(cyc), 64'd8);
        check_val("busy-start product", {48'd0, prod8}, 64'h0023);

        // Back-to-back start in the done cycle.
        start8 = 1'b1; sm8 = 1'b0; mc8 = 8'd12; mp8 = 8'd11;
        @(negedge clk);
        start8 = 1'b0;
        check_val("b2b busy", {63'd0, busy8}, 64'd1);
        check_val("b2b done low", {63'd0, done8}, 64'd0);
        check_val("b2b valid low", {63'd0, pv8}, 64'd0);
        cyc = 0;
        wait_done8(20);
        check_val("b2b latency", 64'(cyc), 64'd8);
        check_val("b2b product", {48'd0, prod8}, 64'h0084);

        // Abort mid-run: no done, valid stays low, old product kept.
        @(negedge clk);
        start8 = 1'b1; mc8 = 8'd9; mp8 = 8'd9;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        ab8 = 1'b1;
        @(negedge clk);
        ab8 = 1'b0;
        check_val("abort busy", {63'd0, busy8}, 64'd0);
        check_val("abort done", {63'd0, done8}, 64'd0);
        check_val("abort valid", {63'd0, pv8}, 64'd0);
        check_val("abort product", {48'd0, prod8}, 64'h0084);
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) done_seen++;
        end
        check_val("abort no done", 64'(done_seen), 64'd0);

        // Abort in IDLE is ignored.
        ab8 = 1'b1;
        @(negedge clk);
        ab8 = 1'b0;
        check_val("idle abort busy", {63'd0, busy8}, 64'd0);
        check_val("idle abort product", {48'd0, prod8}, 64'h0084);

        // Start and abort together in IDLE: start wins.
        start8 = 1'b1; ab8 = 1'b1; sm8 = 1'b1; mc8 = 8'h80; mp8 = 8'h80;
        @(negedge clk);
        start8 = 1'b0; ab8 = 1'b0;
        check_val("start+abort busy", {63'd0, busy8}, 64'd1);
        cyc = 0;
        wait_done8(20);
        check_val("start+abort latency", 64'(cyc), 64'd8);
        check_val("start+abort product", {48'd0, prod8}, 64'h4000);

        // Asynchronous reset between edges while running.
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; mc8 = 8'd6; mp8 = 8'd7;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async rst busy", {63'd0, busy8}, 64'd0);
        check_val("async rst done", {63'd0, done8}, 64'd0);
        check_val("async rst valid", {63'd0, pv8}, 64'd0);
        check_val("async rst product", {48'd0, prod8}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) done_seen++;
        end
        check_val("post rst no done", 64'(done_seen), 64'd0);

        // Wide regressions.
        run32("u32 max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run32("s32 min", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run32("s32 -2x3", 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seq_mult_shift_add
